mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist.sv | 191 +++++++++++++++++++
 tb/tb_mem_bist.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// March-style memory BIST: walking-bit, all-ones and address-tag
// patterns with full-array sweeps, stopping at the first mismatch.
module mem_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [BW-1:0]         B_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] D_LAST = DATA_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, WR, RD, CMP, SWP_RD, SWP_CMP, DONE
    } state_t;

    state_t                state, nxt_state;
    logic [1:0]            phase, nxt_phase;
    logic [ADDR_WIDTH-1:0] addr, nxt_addr;
    logic [BW-1:0]         bidx, nxt_bidx;
    logic                  clr, nxt_clr;
    logic                  sweep, checking, mismatch, launch;
    logic                  nxt_busy, nxt_ren;
    logic [DATA_WIDTH-1:0] exp_word, nxt_word;

    // Pattern word for a phase; z selects the cleared word of phase 1.
    function automatic logic [DATA_WIDTH-1:0] word_of(
        input logic [1:0]            ph,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [BW-1:0]         b,
        input logic                  z
    );
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        unique case (ph)
            2'd0:    w = '0;
            2'd1:    w = z ? '0 : (DATA_WIDTH'(1) << b);
            2'd2:    w = '1;
            default: w = D_LAST - DATA_WIDTH'(a);
        endcase
        return w;
    endfunction

    assign mem_size = 3'b000;
    assign mem_req  = busy;

    assign sweep    = (state == SWP_RD) || (state == SWP_CMP);
    assign checking = (state == CMP) || (state == SWP_CMP);
    assign exp_word = word_of(phase, addr, bidx, clr | sweep);
    assign mismatch = checking && (mem_rd_data != exp_word);
    assign launch   = start && ((state == IDLE) || (state == DONE));
    assign nxt_word = word_of(nxt_phase, nxt_addr, nxt_bidx, nxt_clr);

    assign nxt_busy = (nxt_state != IDLE) && (nxt_state != DONE);
    assign nxt_ren  = (nxt_state == RD) || (nxt_state == CMP) ||
                      (nxt_state == SWP_RD) || (nxt_state == SWP_CMP);

    // Step sequencer: picks the next state and pattern counters.
    always_comb begin
        nxt_state = state;
        nxt_phase = phase;
        nxt_addr  = addr;
        nxt_bidx  = bidx;
        nxt_clr   = clr;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    nxt_state = WR;
                    nxt_phase = 2'd0;
                    nxt_addr  = '0;
                    nxt_bidx  = '0;
                    nxt_clr   = 1'b0;
                end
            end
            WR: begin
                if (phase == 2'd1 && clr) begin
                    nxt_bidx = '0;
                    nxt_clr  = 1'b0;
                    if (addr == A_LAST) begin
                        nxt_state = SWP_RD;
                        nxt_addr  = '0;
                    end else begin
                        nxt_state = WR;
                        nxt_addr  = addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    nxt_state = RD;
                end
            end
            RD: nxt_state = CMP;
            CMP: begin
                if (mismatch) begin
                    nxt_state = DONE;
                end else if (phase == 2'd1 && bidx != B_LAST) begin
                    nxt_state = WR;
                    nxt_bidx  = bidx + BW'(1);
                end else if (phase == 2'd1) begin
                    nxt_state = WR;
                    nxt_clr   = 1'b1;
                end else if (addr == A_LAST) begin
                    nxt_state = SWP_RD;
                    nxt_addr  = '0;
                end else begin
                    nxt_state = WR;
                    nxt_addr  = addr + ADDR_WIDTH'(1);
                end
            end
            SWP_RD: nxt_state = SWP_CMP;
            SWP_CMP: begin
                if (mismatch) begin
                    nxt_state = DONE;
                end else if (addr != A_LAST) begin
                    nxt_state = SWP_RD;
                    nxt_addr  = addr + ADDR_WIDTH'(1);
                end else if (phase == 2'd3) begin
                    nxt_state = DONE;
                end else begin
                    nxt_state = WR;
                    nxt_phase = phase + 2'd1;
                    nxt_addr  = '0;
                    nxt_bidx  = '0;
                    nxt_clr   = 1'b0;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State, registered memory controls and first-failure capture.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= IDLE;
            phase       <= 2'd0;
            addr        <= '0;
            bidx        <= '0;
            clr         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_exp    <= '0;
            fail_data   <= '0;
            mem_wen     <= 1'b0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            state       <= nxt_state;
            phase       <= nxt_phase;
            addr        <= nxt_addr;
            bidx        <= nxt_bidx;
            clr         <= nxt_clr;
            busy        <= nxt_busy;
            done        <= (nxt_state == DONE);
            mem_wen     <= (nxt_state == WR);
            mem_ren     <= nxt_ren;
            mem_addr    <= nxt_busy ? nxt_addr : '0;
            mem_wr_data <= (nxt_state == WR) ? nxt_word : '0;
            if (launch) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_exp  <= '0;
                fail_data <= '0;
            end else if (mismatch) begin
                fail      <= 1'b1;
                fail_addr <= addr;
                fail_exp  <= exp_word;
                fail_data <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: faulty behavioural memory, op-list reference
// model of the march sequence, directed and randomized fault runs.
module tb_mem_bist;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail, mem_req, mem_wen, mem_ren;
    logic [1:0] fail_addr, mem_addr;
    logic [7:0] fail_exp, fail_data, mem_wr_data, mem_rd_data;
    logic [2:0] mem_size;

    int n_tests = 0;
    int n_fail  = 0;

    // fault configuration of the behavioural memory
    logic       f_stuck = 1'b0, f_sv = 1'b0, f_alias = 1'b0;
    logic [1:0] f_sa = '0, f_src = '0, f_dst = '0;
    logic [2:0] f_sb = '0;

    logic [7:0] mem [4];
    logic [1:0] phys;
    logic [7:0] raw, smask;

    typedef struct packed {
        logic       w;
        logic [1:0] a;
        logic [7:0] v;
    } op_t;

    op_t         ops[$];
    logic [9:0]  wlog_dut[$];
    logic [9:0]  wlog_mod[$];

    always #5 clk = ~clk;

    mem_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut (
        .clk(clk), .res(res), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_exp(fail_exp),
        .fail_data(fail_data), .mem_req(mem_req),
        .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    assign phys  = (f_alias && mem_addr == f_src) ? f_dst : mem_addr;
    assign raw   = mem[phys];
    assign smask = 8'd1 << f_sb;
    assign mem_rd_data = (f_stuck && phys == f_sa) ?
        (f_sv ? (raw | smask) : (raw & ~smask)) : raw;

    always @(posedge clk) if (mem_wen) mem[phys] <= mem_wr_data;

    function automatic logic [1:0] m_phys(input logic [1:0] a);
        return (f_alias && a == f_src) ? f_dst : a;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] v,
                                          input logic [1:0] p);
        logic [7:0] m;
        m = 8'd1 << f_sb;
        if (f_stuck && p == f_sa) return f_sv ? (v | m) : (v & ~m);
        return v;
    endfunction

    function automatic logic [7:0] pat(input int ph, input int a);
        if (ph == 2) return 8'hFF;
        if (ph == 3) return 8'(3 - a);
        return 8'h00;
    endfunction

    // Reference: list the test operations, then replay them on a copy
    // of the memory; every write costs 1 cycle, every check 2.
    task automatic model(output int cyc, output logic mf,
                         output logic [17:0] info);
        logic [7:0] mm [4];
        logic [7:0] r, val;
        logic [1:0] p;
        ops.delete();
        wlog_mod.delete();
        for (int i = 0; i < 4; i++) mm[i] = mem[i];
        for (int ph = 0; ph < 4; ph++) begin
            for (int a = 0; a < 4; a++) begin
                if (ph == 1) begin
                    for (int j = 0; j < 8; j++) begin
                        val = 8'd1 << j;
                        ops.push_back({1'b1, 2'(a), val});
                        ops.push_back({1'b0, 2'(a), val});
                    end
                    ops.push_back({1'b1, 2'(a), 8'h00});
                end else begin
                    ops.push_back({1'b1, 2'(a), pat(ph, a)});
                    ops.push_back({1'b0, 2'(a), pat(ph, a)});
                end
            end
            for (int a = 0; a < 4; a++)
                ops.push_back({1'b0, 2'(a), pat(ph, a)});
        end
        cyc = 0;
        mf = 1'b0;
        info = '0;
        foreach (ops[k]) begin
            if (!mf) begin
                p = m_phys(ops[k].a);
                if (ops[k].w) begin
                    mm[p] = ops[k].v;
                    wlog_mod.push_back({ops[k].a, ops[k].v});
                    cyc += 1;
                end else begin
                    cyc += 2;
                    r = m_read(mm[p], p);
                    if (r != ops[k].v) begin
                        mf = 1'b1;
                        info = {ops[k].a, ops[k].v, r};
                    end
                end
            end
        end
    endtask

    // Pulse start, count busy cycles until done, log writes, watch
    // protocol rules; snap is taken right after start is accepted.
    task automatic run_bist(input bit repulse, output int cyc,
                            output bit bad, output logic [20:0] snap);
        int n;
        cyc = 0;
        bad = 1'b0;
        n = 0;
        wlog_dut.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        snap = {busy, done, fail, fail_addr, fail_exp, fail_data};
        while (!done && n < 3000) begin
            if (busy) cyc++;
            if (mem_wen) wlog_dut.push_back({mem_addr, mem_wr_data});
            if (mem_req !== busy || mem_size !== 3'b000) bad = 1'b1;
            if (mem_wen && mem_ren) bad = 1'b1;
            if ((mem_wen || mem_ren) && !busy) bad = 1'b1;
            if (repulse && n == 30) start = 1'b1;
            if (repulse && n == 32) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (wlog_dut.size() != wlog_mod.size()) bad = 1'b1;
        else foreach (wlog_dut[k])
            if (wlog_dut[k] !== wlog_mod[k]) bad = 1'b1;
    endtask

    task automatic set_fault(input bit st, input bit al);
        @(negedge clk);
        f_stuck = st;
        f_alias = al;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset;
        res = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, fail, mem_req, mem_wen, mem_ren, fail_addr,
             fail_exp, fail_data, mem_addr, mem_wr_data} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b wen=%b ren=%b",
                     busy, done, mem_wen, mem_ren);
        end
        res = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_clean;
        int mc, dc; logic mf; logic [17:0] mi; bit bad;
        logic [20:0] snap;
        set_fault(1'b0, 1'b0);
        model(mc, mf, mi);
        run_bist(1'b0, dc, bad, snap);
        n_tests++;
        if (dc !== 168 || mc !== 168) begin
            n_fail++;
            $display("FAIL clean_cycles: got %0d model %0d want 168",
                     dc, mc);
        end
        n_tests++;
        if ({done, fail, fail_addr, fail_exp, fail_data} !== 20'h80000) begin
            n_fail++;
            $display("FAIL clean_status: done=%b fail=%b fa=%0d fe=%h fd=%h",
                     done, fail, fail_addr, fail_exp, fail_data);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL clean_protocol: write log or handshake wrong");
        end
    endtask

    task automatic test_fault(input string nm, input logic [17:0] want);
        int mc, dc; logic mf; logic [17:0] mi; bit bad;
        logic [20:0] snap;
        model(mc, mf, mi);
        run_bist(1'b0, dc, bad, snap);
        n_tests++;
        if (done !== 1'b1 || fail !== 1'b1 ||
            {fail_addr, fail_exp, fail_data} !== want) begin
            n_fail++;
            $display("FAIL %s: done=%b fail=%b got %0d/%h/%h want %0d/%h/%h",
                     nm, done, fail, fail_addr, fail_exp, fail_data,
                     want[17:16], want[15:8], want[7:0]);
        end
        n_tests++;
        if (dc !== mc || mi !== want || bad) begin
            n_fail++;
            $display("FAIL %s_timing: cycles %0d model %0d bad=%b",
                     nm, dc, mc, bad);
        end
    endtask

    task automatic test_stuck_a1b0;
        set_fault(1'b1, 1'b0);
        f_sa = 2'd1; f_sb = 3'd0; f_sv = 1'b1;
        test_fault("stuck1_a1b0", {2'd1, 8'h00, 8'h01});
    endtask

    task automatic test_stuck_a2b3;
        set_fault(1'b1, 1'b0);
        f_sa = 2'd2; f_sb = 3'd3; f_sv = 1'b0;
        test_fault("stuck0_a2b3", {2'd2, 8'h08, 8'h00});
    endtask

    task automatic test_alias;
        set_fault(1'b0, 1'b1);
        f_src = 2'd1; f_dst = 2'd0;
        test_fault("alias_1to0", {2'd0, 8'h03, 8'h02});
    endtask

    task automatic test_restart;
        int mc, dc; logic mf; logic [17:0] mi; bit bad;
        logic [20:0] snap;
        set_fault(1'b0, 1'b0);
        model(mc, mf, mi);
        run_bist(1'b0, dc, bad, snap);
        n_tests++;
        if (snap !== 21'h100000) begin
            n_fail++;
            $display("FAIL restart_clear: snap=%h want 100000", snap);
        end
        n_tests++;
        if (dc !== mc || done !== 1'b1 || fail !== 1'b0 || bad) begin
            n_fail++;
            $display("FAIL restart_run: cycles %0d want %0d fail=%b",
                     dc, mc, fail);
        end
    endtask

    task automatic test_back_to_back;
        int mc, dc; logic mf; logic [17:0] mi; bit bad;
        logic [20:0] snap;
        set_fault(1'b0, 1'b0);
        model(mc, mf, mi);
        run_bist(1'b1, dc, bad, snap);
        n_tests++;
        if (dc !== 168 || done !== 1'b1 || fail !== 1'b0 || bad) begin
            n_fail++;
            $display("FAIL repulse_busy: cycles %0d want 168 fail=%b",
                     dc, fail);
        end
    endtask

    task automatic test_reset_midrun;
        int mc, dc; logic mf; logic [17:0] mi; bit bad;
        logic [20:0] snap;
        set_fault(1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        res = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, fail, mem_req, mem_wen, mem_ren, fail_addr,
             fail_exp, fail_data, mem_addr, mem_wr_data} !== 34'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b wen=%b ren=%b addr=%0d",
                     busy, mem_wen, mem_ren, mem_addr);
        end
        repeat (2) @(negedge clk);
        res = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_idle: busy=%b done=%b want 0 0",
                     busy, done);
        end
        model(mc, mf, mi);
        run_bist(1'b0, dc, bad, snap);
        n_tests++;
        if (dc !== 168 || done !== 1'b1 || fail !== 1'b0 || bad) begin
            n_fail++;
            $display("FAIL midrun_rerun: cycles %0d want 168 fail=%b",
                     dc, fail);
        end
    endtask

    task automatic test_random;
        int mc, dc, kind; logic mf; logic [17:0] mi; bit bad;
        logic [20:0] snap;
        for (int it = 0; it < 10; it++) begin
            kind = int'($urandom_range(0, 2));
            set_fault(kind == 1, kind == 2);
            f_sa  = 2'($urandom);
            f_sb  = 3'($urandom);
            f_sv  = 1'($urandom);
            f_src = 2'($urandom);
            f_dst = f_src + 2'($urandom_range(1, 3));
            model(mc, mf, mi);
            run_bist(1'b0, dc, bad, snap);
            n_tests++;
            if (done !== 1'b1 || fail !== mf || dc !== mc || bad ||
                {fail_addr, fail_exp, fail_data} !== mi) begin
                n_fail++;
                $display("FAIL random_%0d: kind %0d fail %b/%b cyc %0d/%0d info %h/%h bad=%b",
                         it, kind, fail, mf, dc, mc,
                         {fail_addr, fail_exp, fail_data}, mi, bad);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        test_reset;
        test_clean;
        test_stuck_a1b0;
        test_stuck_a2b3;
        test_alias;
        test_restart;
        test_back_to_back;
        test_reset_midrun;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
